// File: rtl/peripheral_dispscan.sv
// Four-digit multiplexed display scanner with shadow/active digit registers,
// frame-synchronous update, anti-ghost blanking and leading-zero blanking.
module peripheral_dispscan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [5:0] wdata,
    input  logic       lzb,
    output logic [3:0] D,
    output logic       EXTENDED,
    output logic [3:0] AN,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

    typedef struct packed {
        logic       en;
        logic       ext;
        logic [3:0] nib;
    } digit_t;

    typedef enum logic {
        BLANK,
        SHOW
    } slot_e;

    localparam digit_t RST_DIG = '{en: 1'b1, ext: 1'b0, nib: 4'd0};

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          pending;
    digit_t        shadow [4];
    digit_t        active [4];

    logic          boundary;
    logic          copy;
    digit_t        eff [4];
    digit_t        cur;
    logic [3:0]    sup;
    logic          hi_ok;
    logic          zero;
    slot_e         slot;
    logic [3:0]    an_nxt;

    // Outputs are derived from the post-copy view so a new frame is
    // consistent from its very first cycle.
    always_comb begin
        boundary = (cnt == '0) && (idx == 2'd0);
        copy     = boundary && pending;
        for (int i = 0; i < 4; i++) begin
            eff[i] = copy ? shadow[i] : active[i];
        end
        hi_ok = 1'b1;
        zero  = 1'b0;
        sup   = '0;
        for (int i = 3; i >= 1; i--) begin
            zero   = !eff[i].ext && (eff[i].nib == 4'd0);
            sup[i] = !eff[i].en || (lzb && zero && hi_ok);
            hi_ok  = hi_ok && (sup[i] || zero);
        end
        sup[0] = !eff[0].en;
        cur    = eff[idx];
        slot   = (cnt < BLK) ? BLANK : SHOW;
        an_nxt = 4'b1111;
        if (slot == SHOW && !sup[idx]) begin
            an_nxt = ~(4'b0001 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pending    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= RST_DIG;
                active[i] <= RST_DIG;
            end
            D          <= 4'd0;
            EXTENDED   <= 1'b0;
            AN         <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (copy) begin
                active <= eff;
            end
            // A write racing the copy keeps pending for the next frame.
            if (we) begin
                shadow[addr] <= digit_t'(wdata);
                pending      <= 1'b1;
            end else if (copy) begin
                pending      <= 1'b0;
            end
            D          <= cur.nib;
            EXTENDED   <= cur.ext;
            AN         <= an_nxt;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_peripheral_dispscan.sv
// Directed bench for peripheral_dispscan with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_peripheral_dispscan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [5:0] wdata = 6'd0;
    logic       lzb = 1'b0;
    logic [3:0] D;
    logic       EXTENDED;
    logic [3:0] AN;
    logic       frame_tick;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    peripheral_dispscan #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lzb       (lzb),
        .D         (D),
        .EXTENDED  (EXTENDED),
        .AN        (AN),
        .frame_tick(frame_tick)
    );

    task automatic wr(input logic [1:0] a, input logic [5:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        vectors++;
        if (frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL %s wait_frame: frame_tick=%b want 1 within 100 cycles",
                     name, frame_tick);
        end
    endtask

    // Called at the negedge showing a frame start; ends at the next one.
    task automatic check_frame(input string name, input logic [15:0] ed,
                               input logic [3:0] ee, input logic [3:0] es);
        for (int c = 0; c < 32; c++) begin
            int s;
            int k;
            logic [3:0] ea;
            logic [3:0] edd;
            logic ex;
            logic et;
            s   = c / 8;
            k   = c % 8;
            ea  = (k < 2 || es[s]) ? 4'b1111 : ~(4'b0001 << s);
            edd = ed[4*s +: 4];
            ex  = ee[s];
            et  = (c == 0);
            vectors++;
            if ({AN, D, EXTENDED, frame_tick} !== {ea, edd, ex, et}) begin
                miscompares++;
                $display("FAIL %s c=%0d: AN=%b D=%h EXT=%b tick=%b want AN=%b D=%h EXT=%b tick=%b",
                         name, c, AN, D, EXTENDED, frame_tick, ea, edd, ex, et);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({AN, D, EXTENDED, frame_tick} !== {4'b1111, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: AN=%b D=%h EXT=%b tick=%b want AN=1111 D=0 EXT=0 tick=0",
                     AN, D, EXTENDED, frame_tick);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_frame("post_reset", 16'h0000, 4'b0000, 4'b0000);
    endtask

    task automatic test_digits();
        wr(2'd0, 6'b100001);
        wr(2'd1, 6'b100010);
        wr(2'd2, 6'b100011);
        wr(2'd3, 6'b100100);
        wait_frame("digits");
        check_frame("digits", 16'h4321, 4'b0000, 4'b0000);
    endtask

    task automatic test_lzb();
        lzb = 1'b1;
        wr(2'd3, 6'b100000);
        wr(2'd2, 6'b100000);
        wr(2'd1, 6'b100101);
        wr(2'd0, 6'b100000);
        wait_frame("lzb");
        check_frame("lzb", 16'h0050, 4'b0000, 4'b1100);
        lzb = 1'b0;
    endtask

    task automatic test_boundary_write();
        wr(2'd3, 6'b101001);
        repeat (30) @(negedge clk);
        wr(2'd2, 6'b100111);
        check_frame("bnd_old", 16'h9050, 4'b0000, 4'b0000);
        check_frame("bnd_new", 16'h9750, 4'b0000, 4'b0000);
    endtask

    task automatic test_ext_en();
        wr(2'd1, 6'b111010);
        wr(2'd3, 6'b000000);
        wait_frame("ext_en");
        check_frame("ext_en", 16'h07A0, 4'b0010, 4'b1000);
    endtask

    task automatic test_reset_mid();
        repeat (19) @(negedge clk);
        vectors++;
        if ({AN, D} !== {4'b1011, 4'h7}) begin
            miscompares++;
            $display("FAIL pre_reset_slot2: AN=%b D=%h want AN=1011 D=7", AN, D);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({AN, D, EXTENDED, frame_tick} !== {4'b1111, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: AN=%b D=%h EXT=%b tick=%b want AN=1111 D=0 EXT=0 tick=0",
                     AN, D, EXTENDED, frame_tick);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_frame("after_mid_reset", 16'h0000, 4'b0000, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_digits();
        test_lzb();
        test_boundary_write();
        test_ext_en();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/peripheral_dispscan.md
PERIPHERAL_DISPSCAN -- requirements
Module: peripheral_dispscan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; SHALL be >= 2.
REQ-002 Parameter BLANK_CYCLES, default 500: anti-ghost blank cycles at the start of each slot; SHALL be < REFRESH_DIV.
REQ-003 Port clk, input, 1: the single system clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port we, input, 1: write strobe for one digit's shadow register.
REQ-006 Port addr, input, 2: digit index written (0 = rightmost).
REQ-007 Port wdata, input, 6: [3:0] nibble, [4] extended flag, [5] digit enable.
REQ-008 Port lzb, input, 1: leading-zero blanking enable.
REQ-009 Port D, output, 4: nibble for the downstream 7-segment decoder.
REQ-010 Port EXTENDED, output, 1: extended-glyph select for the downstream decoder.
REQ-011 Port AN, output, 4: digit anodes, active-low; AN[i] drives digit i.
REQ-012 Port frame_tick, output, 1: one-cycle pulse at each frame start.

Function
REQ-013 Storage SHALL be 4 shadow and 4 active registers, each {nibble, ext, en}.
REQ-014 we=1 SHALL write wdata into shadow[addr] on that edge and set a pending flag.
REQ-015 Slot counter cnt SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1 it SHALL return to 0 and digit index idx SHALL advance 0->1->2->3->0.
REQ-016 Frame boundary SHALL be the cycle where cnt returns to 0 and idx returns to 0.
REQ-017 At a frame boundary with pending=1, all shadow registers SHALL be copied to active and pending cleared.
REQ-018 A write on a frame-boundary cycle SHALL update shadow only; the copy SHALL use pre-write shadow contents, and pending SHALL remain 1.
REQ-019 Slot states: BLANK while cnt < BLANK_CYCLES, SHOW otherwise; no other states.
REQ-020 In BLANK, AN SHALL be 4'b1111.
REQ-021 In SHOW, AN SHALL be low only on bit idx, unless digit idx is suppressed.
REQ-022 A digit SHALL be suppressed if active en=0, or if lzb=1, its ext=0, its nibble=0, and every higher-index digit is also suppressed, or is ext=0 with nibble=0.
REQ-023 Digit 0 SHALL never be suppressed by lzb; en=0 still suppresses it.
REQ-024 D and EXTENDED SHALL carry active[idx].nibble and active[idx].ext throughout the slot, including BLANK and suppressed slots.
REQ-025 D, EXTENDED, AN and frame_tick SHALL be registered; each SHALL lag the cnt/idx state that produces it by exactly one cycle.
REQ-026 frame_tick SHALL be 1 for exactly one cycle per frame, corresponding to the frame-boundary state.
REQ-027 Frame period SHALL be 4*REFRESH_DIV cycles, with no stall or skipped slot under any input.

Reset
REQ-028 rst_n=0 at an edge SHALL set cnt=0, idx=0, pending=0, every shadow and active register to {nibble=0, ext=0, en=1}, D=0, EXTENDED=0, AN=4'b1111 and frame_tick=0.
REQ-029 Reset SHALL take priority over we and over any frame-boundary copy, including mid-slot and mid-frame.
REQ-030 The first edge with rst_n=1 SHALL be treated as a frame boundary at cnt=0, idx=0 with pending=0.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-031 Hold rst_n=0 for 3 cycles -> AN=1111, D=0, EXTENDED=0, frame_tick=0; after release, digit 0 shows 0 (AN=1110 from SHOW onward).
REQ-032 Write digits 0..3 = 1,2,3,4 (ext=0, en=1); wait one frame -> per slot, AN=1111 for 2 cycles, then 1110/D=1, 1101/D=2, 1011/D=3 and 0111/D=4, each for 6 cycles.
REQ-033 lzb=1 with digits 3..0 = 0,0,5,0 -> AN stays 1111 in slots 3 and 2; slot 1 shows D=5; slot 0 shows D=0.
REQ-034 Write digit 2 = 7 on the frame-boundary cycle -> the current frame shows the old value; the next frame shows D=7 in slot 2.
REQ-035 Write digit 1 = {nibble=A, ext=1} and digit 3 with en=0 -> slot 1 gives EXTENDED=1, D=A; slot 3 keeps AN=1111.
REQ-036 Assert rst_n=0 for 1 cycle during SHOW of slot 2 -> next cycle AN=1111 and D=0; frame restarts at slot 0; prior writes are gone.
